kamacore_pipeline_controller: RTL and testbench

Central hold/clear sequencer for the kamacore five-stage pipeline. It drives the `hold` and `clear` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage interfaces, and the PC hold. It resolves three conditions:
- load-use hazards, with a one-cycle bubble;
- taken branches, with a two-stage flush;
- multi-cycle data-memory accesses, with a request/ready wait and a timeout watchdog.

---
 rtl/kamacore_pkg.sv | 13 +
 rtl/kamacore_pipeline_controller_if.sv | 78 +++++++
 rtl/kamacore_load_use_detector.sv | 27 ++
 rtl/kamacore_pipeline_controller.sv | 149 ++++++++++++++
 tb/tb_kamacore_pipeline_controller.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/kamacore_pkg.sv
// kamacore shared types and widths.
// Imported by the pipeline controller slice.
package kamacore_pkg;

  localparam int cpu_width      = 32;
  localparam int reg_addr_width = 4;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipeline_state_t;

endpackage

// File: rtl/kamacore_pipeline_controller_if.sv
// Hazard inputs, data-memory handshake and stage
// hold/clear controls of the pipeline controller.
interface kamacore_pipeline_controller_if #(
  parameter int reg_addr_width    = kamacore_pkg::reg_addr_width,
  parameter int stall_count_width = 32
);

  logic [reg_addr_width:0] id_source_register_a;
  logic [reg_addr_width:0] id_source_register_b;
  logic                    id_uses_a;
  logic                    id_uses_b;
  logic [reg_addr_width:0] ex_destination_register;
  logic                    ex_control_memory_read;
  logic                    ex_branch_taken;
  logic                    mem_access;
  logic                    data_memory_ready;
  logic                    data_memory_request;
  logic                    hold_pc;
  logic                    hold_if_id;
  logic                    clear_if_id;
  logic                    hold_id_ex;
  logic                    clear_id_ex;
  logic                    hold_ex_mem;
  logic                    clear_ex_mem;
  logic                    hold_mem_wb;
  logic                    clear_mem_wb;
  logic                    memory_fault;
  logic [stall_count_width-1:0] stall_count;

  modport master (
    input  id_source_register_a,
    input  id_source_register_b,
    input  id_uses_a,
    input  id_uses_b,
    input  ex_destination_register,
    input  ex_control_memory_read,
    input  ex_branch_taken,
    input  mem_access,
    input  data_memory_ready,
    output data_memory_request,
    output hold_pc,
    output hold_if_id,
    output clear_if_id,
    output hold_id_ex,
    output clear_id_ex,
    output hold_ex_mem,
    output clear_ex_mem,
    output hold_mem_wb,
    output clear_mem_wb,
    output memory_fault,
    output stall_count
  );

  modport slave (
    output id_source_register_a,
    output id_source_register_b,
    output id_uses_a,
    output id_uses_b,
    output ex_destination_register,
    output ex_control_memory_read,
    output ex_branch_taken,
    output mem_access,
    output data_memory_ready,
    input  data_memory_request,
    input  hold_pc,
    input  hold_if_id,
    input  clear_if_id,
    input  hold_id_ex,
    input  clear_id_ex,
    input  hold_ex_mem,
    input  clear_ex_mem,
    input  hold_mem_wb,
    input  clear_mem_wb,
    input  memory_fault,
    input  stall_count
  );

endinterface

// File: rtl/kamacore_load_use_detector.sv
// Compares ID source registers against the
// destination of a load sitting in EX.
module kamacore_load_use_detector #(
  parameter int reg_addr_width = kamacore_pkg::reg_addr_width
) (
  input  logic [reg_addr_width:0] rs1_i,
  input  logic [reg_addr_width:0] rs2_i,
  input  logic                    uses_a_i,
  input  logic                    uses_b_i,
  input  logic [reg_addr_width:0] ex_rd_i,
  input  logic                    ex_load_i,
  output logic                    load_use_hazard_o
);

  logic rd_nz;
  logic hit_a;
  logic hit_b;

  // x0 is hardwired, so a load to it never forwards
  assign rd_nz = |ex_rd_i;
  assign hit_a = uses_a_i && (rs1_i == ex_rd_i);
  assign hit_b = uses_b_i && (rs2_i == ex_rd_i);

  assign load_use_hazard_o =
    ex_load_i && rd_nz && (hit_a || hit_b);

endmodule

// File: rtl/kamacore_pipeline_controller.sv
// Pipeline hold/clear sequencer: memory wait with
// timeout, branch flush and load-use bubble.
module kamacore_pipeline_controller
  import kamacore_pkg::*;
#(
  parameter int reg_addr_width    = kamacore_pkg::reg_addr_width,
  parameter int memory_timeout    = 255,
  parameter int stall_count_width = 32
) (
  input  logic clk,
  input  logic reset_n,
  kamacore_pipeline_controller_if.master bus
);

  localparam int tw =
    (memory_timeout < 1) ? 1 : $clog2(memory_timeout + 1);
  localparam logic [tw-1:0] tmax = tw'(memory_timeout);
  localparam logic [stall_count_width-1:0] smax = '1;

  pipeline_state_t state_q, state_d;
  logic [tw-1:0] cnt_q, cnt_d;
  logic fault_q, fault_d;
  logic [stall_count_width-1:0] stall_q, stall_d;

  logic lu;
  logic ready;
  logic in_wait;
  logic hit;
  logic mem_wait;
  logic sel_mw;
  logic sel_br;
  logic sel_lu;
  logic h_pc, h_ifid, h_idex, h_exmem, h_memwb;
  logic c_ifid, c_idex, c_exmem, c_memwb;
  logic req;

  kamacore_load_use_detector #(
    .reg_addr_width(reg_addr_width)
  ) u_lud (
    .rs1_i            (bus.id_source_register_a),
    .rs2_i            (bus.id_source_register_b),
    .uses_a_i         (bus.id_uses_a),
    .uses_b_i         (bus.id_uses_b),
    .ex_rd_i          (bus.ex_destination_register),
    .ex_load_i        (bus.ex_control_memory_read),
    .load_use_hazard_o(lu)
  );

  assign ready   = bus.data_memory_ready;
  assign in_wait = (state_q == MEM_WAIT);
  assign hit     = in_wait && (cnt_q == tmax);

  assign mem_wait =
    (!in_wait && bus.mem_access && !ready) ||
    (in_wait && !ready && !hit);

  // one-hot selects so the decode below is exclusive
  assign sel_mw = mem_wait;
  assign sel_br = !mem_wait && bus.ex_branch_taken;
  assign sel_lu = !mem_wait && !bus.ex_branch_taken && lu;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    stall_d = stall_q;
    if (mem_wait) begin
      state_d = MEM_WAIT;
      cnt_d   = in_wait ? cnt_q + tw'(1) : '0;
    end else begin
      state_d = RUN;
      cnt_d   = '0;
    end
    if (in_wait && !ready && hit) begin
      fault_d = 1'b1;
    end
    if (h_pc && (stall_q != smax)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_comb begin
    h_pc    = 1'b0;
    h_ifid  = 1'b0;
    h_idex  = 1'b0;
    h_exmem = 1'b0;
    h_memwb = 1'b0;
    c_ifid  = 1'b0;
    c_idex  = 1'b0;
    c_exmem = 1'b0;
    c_memwb = 1'b0;
    req     = 1'b0;
    if (!reset_n) begin
      c_ifid  = 1'b1;
      c_idex  = 1'b1;
      c_exmem = 1'b1;
      c_memwb = 1'b1;
    end else begin
      req = bus.mem_access;
      unique case (1'b1)
        sel_mw: begin
          h_pc    = 1'b1;
          h_ifid  = 1'b1;
          h_idex  = 1'b1;
          h_exmem = 1'b1;
          c_memwb = 1'b1;
        end
        sel_br: begin
          c_ifid = 1'b1;
          c_idex = 1'b1;
        end
        sel_lu: begin
          h_pc   = 1'b1;
          h_ifid = 1'b1;
          c_idex = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      stall_q <= stall_d;
    end
  end

  assign bus.data_memory_request = req;
  assign bus.hold_pc      = h_pc;
  assign bus.hold_if_id   = h_ifid;
  assign bus.clear_if_id  = c_ifid;
  assign bus.hold_id_ex   = h_idex;
  assign bus.clear_id_ex  = c_idex;
  assign bus.hold_ex_mem  = h_exmem;
  assign bus.clear_ex_mem = c_exmem;
  assign bus.hold_mem_wb  = h_memwb;
  assign bus.clear_mem_wb = c_memwb;
  assign bus.memory_fault = fault_q;
  assign bus.stall_count  = stall_q;

endmodule

// File: tb/tb_kamacore_pipeline_controller.sv
// Directed bench for the pipeline controller with a
// queue of expected stage-control vectors.
module tb_kamacore_pipeline_controller;

  localparam logic [9:0] NONE = 10'b00_0000_0000;
  localparam logic [9:0] REQ  = 10'b00_0000_0001;
  localparam logic [9:0] LU   = 10'b11_0000_1000;
  localparam logic [9:0] BR   = 10'b00_0001_1000;
  localparam logic [9:0] MW   = 10'b11_1100_0011;
  localparam logic [9:0] RST  = 10'b00_0001_1110;

  typedef struct {
    string      tag;
    logic [9:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   fails = 0;
  logic [3:0] exp_stall = '0;
  logic       exp_fault = 1'b0;
  exp_t       sb[$];

  kamacore_pipeline_controller_if #(
    .reg_addr_width(4),
    .stall_count_width(4)
  ) bus ();

  kamacore_pipeline_controller #(
    .reg_addr_width(4),
    .memory_timeout(4),
    .stall_count_width(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(
    input logic [4:0] ra, input logic ua,
    input logic [4:0] rb, input logic ub,
    input logic [4:0] rd, input logic ld,
    input logic br, input logic ma, input logic rdy,
    input logic [9:0] e, input string tag
  );
    exp_t x;
    bus.id_source_register_a    = ra;
    bus.id_uses_a               = ua;
    bus.id_source_register_b    = rb;
    bus.id_uses_b               = ub;
    bus.ex_destination_register = rd;
    bus.ex_control_memory_read  = ld;
    bus.ex_branch_taken         = br;
    bus.mem_access              = ma;
    bus.data_memory_ready       = rdy;
    x.tag = tag;
    x.v   = e;
    sb.push_back(x);
  endtask

  task automatic step(input logic fset);
    exp_t x;
    logic [9:0] obs;
    @(negedge clk);
    obs = {bus.hold_pc, bus.hold_if_id, bus.hold_id_ex,
           bus.hold_ex_mem, bus.hold_mem_wb,
           bus.clear_if_id, bus.clear_id_ex,
           bus.clear_ex_mem, bus.clear_mem_wb,
           bus.data_memory_request};
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard empty obs=%b exp=entry", obs);
      x.tag = "none";
      x.v   = NONE;
    end else begin
      x = sb.pop_front();
      assert (obs === x.v) else begin
        fails++;
        $error("FAIL %s ctl obs=%b exp=%b", x.tag, obs, x.v);
      end
    end
    checks++;
    assert (bus.stall_count === exp_stall) else begin
      fails++;
      $error("FAIL %s stall obs=%0d exp=%0d",
             x.tag, bus.stall_count, exp_stall);
    end
    checks++;
    assert (bus.memory_fault === exp_fault) else begin
      fails++;
      $error("FAIL %s fault obs=%b exp=%b",
             x.tag, bus.memory_fault, exp_fault);
    end
    if (x.v[9] && reset_n && exp_stall != 4'hF)
      exp_stall = exp_stall + 4'd1;
    if (fset) exp_fault = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, RST, "reset");
    step(0);
    reset_n = 1'b1;

    drive(5, 1, 0, 0, 5, 1, 0, 0, 0, LU, "lu_a");
    step(0);
    drive(5, 1, 0, 0, 0, 0, 0, 0, 0, NONE, "lu_gone");
    step(0);
    drive(0, 1, 0, 0, 0, 1, 0, 0, 0, NONE, "lu_x0");
    step(0);
    drive(5, 0, 0, 0, 5, 1, 0, 0, 0, NONE, "lu_unused");
    step(0);
    drive(3, 0, 5, 1, 5, 1, 0, 0, 0, LU, "lu_b");
    step(0);

    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, BR, "branch");
    step(0);
    drive(5, 1, 0, 0, 5, 1, 1, 0, 0, BR, "br_over_lu");
    step(0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, "idle");
    step(0);

    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, MW, "mw1");
    step(0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, MW, "mw2");
    step(0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, MW, "mw3");
    step(0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, REQ, "mw_rel");
    step(0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, "mw_done");
    step(0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, REQ, "mw_zero");
    step(0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, "mw_zero2");
    step(0);

    drive(0, 0, 0, 0, 0, 0, 1, 1, 0, MW, "mwbr1");
    step(0);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0, MW, "mwbr2");
    step(0);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1, REQ | BR, "mwbr_rel");
    step(0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, "mwbr_done");
    step(0);

    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, MW, "to_wait");
      step(0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, REQ, "to_hit");
    step(1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, "to_run");
    step(0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, "to_sticky");
    step(0);

    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, MW, "rw1");
    step(0);
    reset_n   = 1'b0;
    exp_stall = '0;
    exp_fault = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, RST, "rw_rst");
    step(0);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, "rw_run");
    step(0);

    for (int i = 0; i < 20; i++) begin
      drive(7, 1, 0, 0, 7, 1, 0, 0, 0, LU, "sat_lu");
      step(0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, "sat_end");
    step(0);
    checks++;
    assert (bus.stall_count === 4'hF) else begin
      fails++;
      $error("FAIL sat_cnt obs=%0d exp=15", bus.stall_count);
    end

    checks++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL sb_left obs=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
